calc_operand_entry: RTL and testbench
=====================================

Name: calc_operand_entry

Overview:
- Keypad-to-operand entry stage for the DE2 calculator.
- Accumulates debounced key codes into two sign-magnitude BCD operands and captures the operator.
- Each operand is 1 sign bit plus 5 BCD digits, 21 bits total.
- On '=' it presents both operands, with a one-cycle valid pulse, to the downstream BCD-to-binary converter and the ALU. It also drives the digit currently being edited to the 7-segment display path.

Parameters:
- DIGITS, 5: BCD digits per operand. Fixed by the downstream 21-bit operand format; other values are unsupported.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- key_valid  in  1  one-cycle strobe; key_code is valid in this cycle
- key_code  in  5  0-9 digit, 10 '+', 11 '-', 12 '*', 13 '/', 14 '=', 15 clear, 16 sign toggle, 17 backspace; 18-31 reserved
- BCDa  out  21  operand A: [20] sign (1 = negative), [19:0] five BCD digits, MS digit first
- BCDb  out  21  operand B, same format as BCDa
- op  out  2  operator: 0 add, 1 sub, 2 mul, 3 div
- operands_valid  out  1  one-cycle pulse when BCDa, BCDb and op are final
- disp_bcd  out  21  operand being edited (A in S_A, B in S_B); BCDb in S_DONE
- state  out  2  0 S_A, 1 S_B, 2 S_DONE
- entry_full  out  1  high while the active operand holds 5 digits

Behaviour:
- Clock and reset:
  - Single clock: clk.
  - Reset rst is asynchronous and active-high.
  - On reset: BCDa = BCDb = 0, op = 0, operands_valid = 0, state = S_A, digit counts = 0, entry_full = 0, disp_bcd = 0.
  - Reset asserted mid-entry discards everything.
- Key handling:
  - Keys are processed only in cycles with key_valid = 1.
  - All outputs are registered; the effect of a key is visible on the cycle after its strobe.
  - Reserved codes are ignored.
- Digit key (S_A or S_B), applied to the active operand:
  - If count = 0 and digit = 0: no change (leading zeros are suppressed).
  - Else if count < 5: magnitude shifts left one digit, the new digit goes into [3:0], count increments.
  - If count = 5: the key is ignored and entry_full stays high.
- Backspace: if count > 0, magnitude shifts right one digit with zero fill into [19:16], count decrements. When count reaches 0, the sign is cleared.
- Sign toggle: inverts [20] of the active operand only when count > 0. A zero value always has sign 0.
- Operator key (10-13):
  - In S_A: latch op and go to S_B. An empty A is accepted as 0.
  - In S_B with count_b = 0: replace op.
  - In S_B with count_b > 0: ignored.
- '=' key:
  - In S_B: go to S_DONE and assert operands_valid for exactly one cycle. BCDa, BCDb and op are held stable from that cycle until the next edit.
  - In S_A or S_DONE: ignored; no pulse is generated.
- Keys in S_DONE:
  - Digit: clear A, B and counts, load the digit as the first digit of A (a 0 loads nothing), go to S_A.
  - Operator, sign toggle, backspace: ignored.
- Clear (any state): same effect as reset, applied synchronously.
- Digit validity: every stored digit is in the range 0-9. Outputs never carry BCD codes A-F.
- Counts: 3-bit counters per operand, range 0..5. They cannot wrap.

Decomposition:
- Shared package calc_pkg holds:
  - key-code constants (KEY_ADD ... KEY_BKSP);
  - state encodings S_A, S_B, S_DONE;
  - op encodings OP_ADD, OP_SUB, OP_MUL, OP_DIV;
  - BCD_OPERAND_W = 21, shared with the BCD-to-binary converter.
- One sub-module: bcd_entry_reg.
  - Holds a single operand register plus its digit counter.
  - Commands: load-digit, backspace, toggle-sign, clear.
  - Instantiated twice, once for A and once for B.
  - The top level holds the FSM, op register and valid pulse.

Test Plan:
- Reset during entry: press 1,2 then assert rst -> BCDa = 0, state = S_A, no operands_valid pulse.
- Basic sequence: keys 1,2,3,'+',4,5,'=' -> BCDa = 0x00123, BCDb = 0x00045, op = 0, operands_valid high for exactly 1 cycle, state = S_DONE.
- Overflow and leading zeros: keys 0,0,9,8,7,6,5,4 -> BCDa = 0x98765, entry_full = 1, the digit 4 is ignored; leading zeros add no count.
- Sign and backspace: keys 7, toggle, 3 -> BCDa = 0x100073. Then backspace, backspace -> BCDa = 0, sign cleared. Then toggle -> BCDa stays 0.
- Operator replacement: keys 5,'*','/',2,'-','=' -> op = 3, BCDb = 0x00002; '-' is ignored after the B digit.
- Post-result restart: after a completed sequence, key 8 -> state = S_A, BCDa = 0x00008, BCDb = 0. Then '=' in S_A -> no pulse.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants for the DE2 calculator datapath: key codes, FSM states,
// operator encodings and the sign-magnitude BCD operand width.
package calc_pkg;

  localparam int DIGITS        = 5;
  localparam int BCD_OPERAND_W = 4 * DIGITS + 1;

  localparam logic [4:0] KEY_ADD  = 5'd10;
  localparam logic [4:0] KEY_SUB  = 5'd11;
  localparam logic [4:0] KEY_MUL  = 5'd12;
  localparam logic [4:0] KEY_DIV  = 5'd13;
  localparam logic [4:0] KEY_EQ   = 5'd14;
  localparam logic [4:0] KEY_CLR  = 5'd15;
  localparam logic [4:0] KEY_SIGN = 5'd16;
  localparam logic [4:0] KEY_BKSP = 5'd17;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  // Operator keys are contiguous, so the op is the offset from KEY_ADD.
  function automatic op_e key_to_op(input logic [4:0] k);
    logic [4:0] d;
    d = k - KEY_ADD;
    return op_e'(d[1:0]);
  endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// One sign-magnitude BCD operand plus its digit count. Commands are mutually
// exclusive except clr+ld, which restarts the operand with a first digit.
module bcd_entry_reg
  import calc_pkg::*;
#(
  parameter int DIGITS = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                ld_i,
  input  logic [3:0]          digit_i,
  input  logic                bksp_i,
  input  logic                tog_i,
  output logic [4*DIGITS:0]   val_o,
  output logic [2:0]          cnt_o
);

  localparam int MAG_W = 4 * DIGITS;

  logic [MAG_W:0] val_q, val_d, base_val;
  logic [2:0]     cnt_q, cnt_d, base_cnt;

  always_comb begin
    base_val = clr_i ? '0 : val_q;
    base_cnt = clr_i ? 3'd0 : cnt_q;
    val_d    = base_val;
    cnt_d    = base_cnt;
    if (ld_i) begin
      // Leading zeros are dropped so the count tracks significant digits only.
      if (!(base_cnt == 3'd0 && digit_i == 4'd0) && base_cnt < 3'(DIGITS)) begin
        val_d[MAG_W-1:0] = {base_val[MAG_W-5:0], digit_i};
        cnt_d            = base_cnt + 3'd1;
      end
    end else if (bksp_i && base_cnt != 3'd0) begin
      val_d[MAG_W-1:0] = {4'h0, base_val[MAG_W-1:4]};
      cnt_d            = base_cnt - 3'd1;
      if (base_cnt == 3'd1) val_d[MAG_W] = 1'b0;
    end else if (tog_i && base_cnt != 3'd0) begin
      val_d[MAG_W] = ~base_val[MAG_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= '0;
      cnt_q <= 3'd0;
    end else begin
      val_q <= val_d;
      cnt_q <= cnt_d;
    end
  end

  assign val_o = val_q;
  assign cnt_o = cnt_q;

endmodule

// File: rtl/calc_operand_entry.sv
// Keypad entry stage: builds operands A and B from key strobes, latches the
// operator and pulses operands_valid when '=' completes the expression.
module calc_operand_entry
  import calc_pkg::*;
#(
  parameter int DIGITS = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     key_valid,
  input  logic [4:0]               key_code,
  output logic [BCD_OPERAND_W-1:0] BCDa,
  output logic [BCD_OPERAND_W-1:0] BCDb,
  output logic [1:0]               op,
  output logic                     operands_valid,
  output logic [BCD_OPERAND_W-1:0] disp_bcd,
  output logic [1:0]               state,
  output logic                     entry_full
);

  state_e state_q, state_d;
  op_e    op_q, op_d;
  logic   vld_q, vld_d;

  logic clr_a, ld_a, bksp_a, tog_a;
  logic clr_b, ld_b, bksp_b, tog_b;
  logic [2:0] cnt_a, cnt_b;
  logic [BCD_OPERAND_W-1:0] val_a, val_b;

  logic is_digit, is_op;
  assign is_digit = key_code < 5'd10;
  assign is_op    = key_code >= KEY_ADD && key_code <= KEY_DIV;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    vld_d   = 1'b0;
    clr_a = 1'b0; ld_a = 1'b0; bksp_a = 1'b0; tog_a = 1'b0;
    clr_b = 1'b0; ld_b = 1'b0; bksp_b = 1'b0; tog_b = 1'b0;
    if (key_valid) begin
      if (key_code == KEY_CLR) begin
        clr_a   = 1'b1;
        clr_b   = 1'b1;
        op_d    = OP_ADD;
        state_d = S_A;
      end else begin
        unique case (state_q)
          S_A: begin
            ld_a   = is_digit;
            bksp_a = key_code == KEY_BKSP;
            tog_a  = key_code == KEY_SIGN;
            if (is_op) begin
              op_d    = key_to_op(key_code);
              state_d = S_B;
            end
          end
          S_B: begin
            ld_b   = is_digit;
            bksp_b = key_code == KEY_BKSP;
            tog_b  = key_code == KEY_SIGN;
            if (is_op && cnt_b == 3'd0) op_d = key_to_op(key_code);
            if (key_code == KEY_EQ) begin
              state_d = S_DONE;
              vld_d   = 1'b1;
            end
          end
          default: begin
            // A digit after a result starts a fresh expression.
            if (is_digit) begin
              clr_a   = 1'b1;
              clr_b   = 1'b1;
              ld_a    = 1'b1;
              state_d = S_A;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_A;
      op_q    <= OP_ADD;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      vld_q   <= vld_d;
    end
  end

  bcd_entry_reg #(.DIGITS(DIGITS)) u_opa (
    .clk(clk), .rst(rst), .clr_i(clr_a), .ld_i(ld_a), .digit_i(key_code[3:0]),
    .bksp_i(bksp_a), .tog_i(tog_a), .val_o(val_a), .cnt_o(cnt_a)
  );

  bcd_entry_reg #(.DIGITS(DIGITS)) u_opb (
    .clk(clk), .rst(rst), .clr_i(clr_b), .ld_i(ld_b), .digit_i(key_code[3:0]),
    .bksp_i(bksp_b), .tog_i(tog_b), .val_o(val_b), .cnt_o(cnt_b)
  );

  assign BCDa           = val_a;
  assign BCDb           = val_b;
  assign op             = op_q;
  assign operands_valid = vld_q;
  assign state          = state_q;
  assign disp_bcd       = (state_q == S_A) ? val_a : val_b;
  assign entry_full     = (state_q == S_A && cnt_a == 3'(DIGITS)) ||
                          (state_q == S_B && cnt_b == 3'(DIGITS));

endmodule

// File: tb/tb_calc_operand_entry.sv
// Directed-vector bench for calc_operand_entry with hand-computed expectations.
module tb_calc_operand_entry;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [4:0]  key_code = 5'd0;
  logic [20:0] BCDa, BCDb, disp_bcd;
  logic [1:0]  op, state;
  logic        operands_valid, entry_full;

  int vectors = 0;
  int errors  = 0;
  int pulses  = 0;

  calc_operand_entry dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .BCDa(BCDa), .BCDb(BCDb), .op(op), .operands_valid(operands_valid),
    .disp_bcd(disp_bcd), .state(state), .entry_full(entry_full)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (operands_valid) pulses++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe one key; returns at the negedge after the capturing posedge.
  task automatic press(input logic [4:0] c);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 5'd0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_bcda", 32'(BCDa), 32'h0);
    chk("rst_bcdb", 32'(BCDb), 32'h0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_op", 32'(op), 32'd0);
    chk("rst_valid", 32'(operands_valid), 32'd0);
    chk("rst_full", 32'(entry_full), 32'd0);
    chk("rst_disp", 32'(disp_bcd), 32'h0);

    // Reset during entry
    press(5'd1); press(5'd2);
    chk("pre_rst_bcda", 32'(BCDa), 32'h12);
    chk("pre_rst_disp", 32'(disp_bcd), 32'h12);
    #2 rst = 1'b1;
    #1 chk("async_rst_bcda", 32'(BCDa), 32'h0);
    @(negedge clk); rst = 1'b0;
    chk("post_rst_state", 32'(state), 32'd0);
    chk("post_rst_pulses", 32'(pulses), 32'd0);

    // Basic sequence 123 + 45 =
    press(5'd1); press(5'd2); press(5'd3);
    press(5'd10);
    chk("basic_state_b", 32'(state), 32'd1);
    press(5'd4); press(5'd5);
    chk("basic_disp_b", 32'(disp_bcd), 32'h45);
    press(5'd20);  // reserved
    chk("reserved_ign", 32'(BCDb), 32'h45);
    press(5'd14);
    chk("basic_valid", 32'(operands_valid), 32'd1);
    chk("basic_bcda", 32'(BCDa), 32'h123);
    chk("basic_bcdb", 32'(BCDb), 32'h45);
    chk("basic_op", 32'(op), 32'd0);
    chk("basic_state", 32'(state), 32'd2);
    chk("basic_disp_done", 32'(disp_bcd), 32'h45);
    @(negedge clk);
    chk("basic_valid_drop", 32'(operands_valid), 32'd0);
    chk("basic_pulses", 32'(pulses), 32'd1);
    press(5'd10);  // operator ignored in S_DONE
    chk("done_op_ign", 32'(state), 32'd2);

    // Post-result restart
    press(5'd8);
    chk("restart_state", 32'(state), 32'd0);
    chk("restart_bcda", 32'(BCDa), 32'h8);
    chk("restart_bcdb", 32'(BCDb), 32'h0);
    press(5'd14);
    chk("eq_in_a_state", 32'(state), 32'd0);
    chk("eq_in_a_valid", 32'(operands_valid), 32'd0);
    chk("eq_in_a_pulses", 32'(pulses), 32'd1);

    // Overflow and leading zeros
    press(5'd15);
    chk("clr_bcda", 32'(BCDa), 32'h0);
    press(5'd0); press(5'd0);
    chk("lead_zero", 32'(BCDa), 32'h0);
    press(5'd9); press(5'd8); press(5'd7); press(5'd6);
    chk("four_digits_full", 32'(entry_full), 32'd0);
    press(5'd5);
    chk("ovf_bcda", 32'(BCDa), 32'h98765);
    chk("ovf_full", 32'(entry_full), 32'd1);
    press(5'd4);
    chk("ovf_ignored", 32'(BCDa), 32'h98765);
    chk("ovf_full_hold", 32'(entry_full), 32'd1);
    press(5'd17);
    chk("ovf_bksp", 32'(BCDa), 32'h09876);
    chk("ovf_bksp_full", 32'(entry_full), 32'd0);

    // Sign and backspace
    press(5'd15);
    press(5'd7); press(5'd16); press(5'd3);
    chk("sign_bcda", 32'(BCDa), 32'h100073);
    press(5'd17);
    chk("sign_bksp1", 32'(BCDa), 32'h100007);
    press(5'd17);
    chk("sign_bksp2", 32'(BCDa), 32'h0);
    press(5'd16);
    chk("sign_zero_tog", 32'(BCDa), 32'h0);

    // Operator replacement
    press(5'd15);
    press(5'd5); press(5'd12); press(5'd13);
    chk("oprep_op", 32'(op), 32'd3);
    press(5'd2);
    press(5'd16);
    chk("b_sign", 32'(BCDb), 32'h100002);
    press(5'd16);
    press(5'd11);
    chk("oprep_ign", 32'(op), 32'd3);
    chk("oprep_state", 32'(state), 32'd1);
    press(5'd14);
    chk("oprep_valid", 32'(operands_valid), 32'd1);
    chk("oprep_final_op", 32'(op), 32'd3);
    chk("oprep_bcda", 32'(BCDa), 32'h5);
    chk("oprep_bcdb", 32'(BCDb), 32'h2);

    // Clear from S_B restores reset state synchronously
    press(5'd1); press(5'd11); press(5'd3);
    press(5'd15);
    chk("clr_b_state", 32'(state), 32'd0);
    chk("clr_b_op", 32'(op), 32'd0);
    chk("clr_b_bcdb", 32'(BCDb), 32'h0);
    chk("clr_b_bcda", 32'(BCDa), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
